// File: rtl/mul_pkg.sv
// Shared codes for the multiplier sequencer: funct values, multiplier commands
// and the sequencer state encoding.
package mul_pkg;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MTLO  = 6'b010011;

  localparam logic [5:0] HOLD  = 6'b000000;
  localparam logic [5:0] OUT   = 6'b111111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    CAPTURE = 2'd3
  } state_t;

endpackage

// File: rtl/mul_hilo_ctrl.sv
// MULTU sequencer and HI/LO result registers downstream of the shift-add multiplier.
// Build option: define MTHILO_EN to enable MTHI/MTLO writes from wdata.
module mul_hilo_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         funct,
  input  logic               start,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [2*WIDTH-1:0] mulProduct,
  output logic [5:0]         mulSignal,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic [WIDTH-1:0]   dataOut,
  output state_t             dbg_state
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] count;

  // Handshake: start is accepted only on an edge where the sequencer is IDLE;
  // busy stays high from that edge until the capture edge, and done is a
  // single-cycle pulse after the capture edge. Starts seen while busy are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      mulSignal <= HOLD;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && funct == MULTU) begin
            state     <= LOAD;
            mulSignal <= OUT;
            busy      <= 1'b1;
            count     <= '0;
          end
`ifdef MTHILO_EN
          else if (start && funct == MTHI) begin
            hi <= wdata;
          end else if (start && funct == MTLO) begin
            lo <= wdata;
          end
`endif
        end
        LOAD: begin
          state     <= RUN;
          mulSignal <= MULTU;
        end
        RUN: begin
          // Count saturates at LAST; the exit edge leaves it there.
          if (count == LAST) begin
            state     <= CAPTURE;
            mulSignal <= HOLD;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        CAPTURE: begin
          hi    <= mulProduct[2*WIDTH-1:WIDTH];
          lo    <= mulProduct[WIDTH-1:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          mulSignal <= HOLD;
        end
      endcase
    end
  end

`ifndef MTHILO_EN
  logic unused_wdata;
  assign unused_wdata = ^wdata;
`endif

  assign dataOut   = (funct == MFHI) ? hi : (funct == MFLO) ? lo : '0;
  assign dbg_state = state;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Randomised scoreboard bench for mul_hilo_ctrl with a behavioural shift-add
// multiplier stand-in and a spec-level reference model of HI/LO and timing.
module tb_mul_hilo_ctrl;
  import mul_pkg::*;

  localparam int W   = 32;
  localparam int NMC = 32;
  localparam int LAT = NMC + 2;
`ifdef MTHILO_EN
  localparam bit MT_EN = 1'b1;
`else
  localparam bit MT_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [5:0]     funct = 6'd0;
  logic           start = 1'b0;
  logic [W-1:0]   wdata = '0;
  logic [2*W-1:0] mulProduct;
  logic [5:0]     mulSignal;
  logic           busy, done;
  logic [W-1:0]   hi, lo, dataOut;
  state_t         dbg_state;

  mul_hilo_ctrl #(.WIDTH(W), .MUL_CYCLES(NMC), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .funct(funct), .start(start), .wdata(wdata),
    .mulProduct(mulProduct), .mulSignal(mulSignal), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .dataOut(dataOut), .dbg_state(dbg_state)
  );

  // Stand-in multiplier: full product only after exactly NMC MULTU steps since OUT.
  logic [W-1:0] dataA = '0, dataB = '0;
  logic [W-1:0] ma = '0, mb = '0;
  int steps = 0;
  always @(posedge clk) begin
    if (mulSignal == OUT) begin
      ma <= dataA; mb <= dataB; steps <= 0;
    end else if (mulSignal == MULTU) begin
      steps <= steps + 1;
    end
  end
  assign mulProduct = (steps == NMC) ? {32'b0, ma} * {32'b0, mb}
                                     : {32'hBAD0BAD0, 32'(steps)};

  // scoreboard: expected register updates (kind 0 = multiply, 1 = MTHI, 2 = MTLO)
  logic [2*W-1:0] exp_q[$];
  int             exp_cyc_q[$];
  logic [1:0]     exp_kind_q[$];

  // request-side model state, owned by the stimulus process
  int last_e  = 0;
  int free_at = 0;
  bit live    = 1'b0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // monitor: applies due model updates and compares every output each negedge
  logic [W-1:0] m_hi = '0, m_lo = '0;
  always @(negedge clk) begin
    logic           exp_done;
    logic [2*W-1:0] v;
    logic [1:0]     k;
    logic [5:0]     exp_sig;
    logic [W-1:0]   exp_out;
    int             d, c;
    if (reset) begin
      exp_q.delete(); exp_cyc_q.delete(); exp_kind_q.delete();
      m_hi = '0; m_lo = '0;
      chk("rst_hi", {32'b0, hi}, 64'd0);
      chk("rst_lo", {32'b0, lo}, 64'd0);
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_done", {63'b0, done}, 64'd0);
      chk("rst_sig", {58'b0, mulSignal}, {58'b0, HOLD});
    end else begin
      exp_done = 1'b0;
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
        c = exp_cyc_q.pop_front();
        v = exp_q.pop_front();
        k = exp_kind_q.pop_front();
        if (c != cyc) chk("sb_order", 64'(c), 64'(cyc));
        case (k)
          2'd0: begin m_hi = v[2*W-1:W]; m_lo = v[W-1:0]; exp_done = 1'b1; end
          2'd1: m_hi = v[W-1:0];
          default: m_lo = v[W-1:0];
        endcase
      end
      d = cyc - last_e;
      if (live && d == 0) exp_sig = OUT;
      else if (live && d >= 1 && d <= NMC) exp_sig = MULTU;
      else exp_sig = HOLD;
      exp_out = (funct == MFHI) ? m_hi : (funct == MFLO) ? m_lo : '0;
      chk("done", {63'b0, done}, {63'b0, exp_done});
      chk("busy", {63'b0, busy}, {63'b0, live && d < LAT});
      chk("mulSignal", {58'b0, mulSignal}, {58'b0, exp_sig});
      chk("hi", {32'b0, hi}, {32'b0, m_hi});
      chk("lo", {32'b0, lo}, {32'b0, m_lo});
      chk("dataOut", {32'b0, dataOut}, {32'b0, exp_out});
    end
  end

  // driver: called #1 after a posedge; holds operands through the LOAD cycle
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] wd);
    funct = f; dataA = a; dataB = b; wdata = wd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (cyc >= free_at) begin
      if (f == MULTU) begin
        exp_q.push_back({32'b0, a} * {32'b0, b});
        exp_cyc_q.push_back(cyc + LAT);
        exp_kind_q.push_back(2'd0);
        last_e = cyc; free_at = cyc + LAT + 1; live = 1'b1;
      end else if (MT_EN && (f == MTHI || f == MTLO)) begin
        exp_q.push_back({32'b0, wd});
        exp_cyc_q.push_back(cyc);
        exp_kind_q.push_back((f == MTHI) ? 2'd1 : 2'd2);
      end
    end
    funct = 6'd0;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic read_all();
    funct = MFHI; idle_cycles(1);
    funct = MFLO; idle_cycles(1);
    funct = 6'd0; idle_cycles(1);
  endtask

  initial begin
    logic [5:0] codes [6];
    codes[0] = MULTU; codes[1] = MFHI; codes[2] = MFLO;
    codes[3] = MTHI;  codes[4] = MTLO; codes[5] = 6'd0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle_cycles(2);

    // small product
    issue(MULTU, 32'd3, 32'd5, '0);
    idle_cycles(LAT + 2);
    read_all();

    // maximum operands, then reads
    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, '0);
    idle_cycles(LAT + 2);
    read_all();

    // second start while busy is dropped
    issue(MULTU, 32'h12345678, 32'h9ABC, '0);
    idle_cycles(5);
    issue(MULTU, 32'h77777777, 32'h55555555, '0);
    funct = MFLO;
    idle_cycles(LAT);
    funct = 6'd0;
    read_all();

    // back-to-back: new start sampled on the edge after done rises
    issue(MULTU, 32'hCAFEF00D, 32'h1234ABCD, '0);
    idle_cycles(LAT - 1);
    issue(MULTU, 32'h0BADBEEF, 32'h00010001, '0);
    idle_cycles(LAT + 2);
    read_all();

    // MTHI / MTLO in idle and while busy
    issue(MTHI, '0, '0, 32'hDEADBEEF);
    issue(MTLO, '0, '0, 32'h13579BDF);
    read_all();
    issue(MULTU, 32'd7, 32'd9, '0);
    issue(MTHI, '0, '0, 32'hFEEDFACE);
    idle_cycles(LAT + 2);
    read_all();

    // randomised mix with reads during busy
    for (int i = 0; i < 24; i++) begin
      issue(codes[$urandom_range(0, 5)], $urandom, $urandom, $urandom);
      funct = codes[$urandom_range(1, 5)];
      idle_cycles($urandom_range(0, 40));
      funct = 6'd0;
    end
    idle_cycles(LAT + 2);

    // reset mid-run at count 10 aborts without a done pulse
    issue(MULTU, 32'hAAAA5555, 32'h3, '0);
    idle_cycles(10);
    reset = 1'b1; live = 1'b0; free_at = 0;
    idle_cycles(2);
    reset = 1'b0;
    idle_cycles(LAT + 4);
    read_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_hilo_ctrl.md
Name: mul_hilo_ctrl

Overview:
Sequencer and HI/LO result register stage that sits directly downstream of the shift-add unsigned multiplier.
- On a MULTU request it drives the multiplier's 6-bit Signal input through a load, 32 shift-add cycles and a capture.
- It latches the 64-bit product into HI/LO and serves MFHI/MFLO reads to the ALU output mux.
- It gives the datapath a busy/done handshake, so the control unit never counts multiply cycles itself.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits, product is 2*WIDTH.
MUL_CYCLES, 32, number of MULTU cycles driven to the multiplier; must be ≤ 2^CNT_W.
CNT_W, 6, cycle counter width.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
funct  in  6  function code: MULTU 6'b011001, MFHI 6'b010000, MFLO 6'b010010, MTHI 6'b010001, MTLO 6'b010011.
start  in  1  request strobe, qualified by funct; sampled on rising clk.
wdata  in  WIDTH  write data for MTHI/MTLO; ignored unless MTHILO_EN is defined.
mulProduct  in  2*WIDTH  product from the multiplier dataOut.
mulSignal  out  6  drives the multiplier Signal input: HOLD 6'b000000, OUT 6'b111111, MULTU 6'b011001.
busy  out  1  high while a multiply is in flight.
done  out  1  one-cycle pulse when HI/LO have been updated by a multiply.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.
dataOut  out  WIDTH  combinational read: hi when funct==MFHI, lo when funct==MFLO, else 0.

Behaviour:
Reset (asynchronous, any state): state=IDLE, count=0, hi=0, lo=0, done=0, busy=0, mulSignal=HOLD.

FSM states IDLE, LOAD, RUN, CAPTURE; mulSignal is a registered Moore output per state:
- IDLE (HOLD): on start && funct==MULTU, go to LOAD, busy<=1, count<=0. Any other funct with start causes no state change.
- LOAD (OUT): the multiplier latches dataA/dataB and clears its product. Operands must be stable during this cycle. Next state RUN.
- RUN (MULTU): count increments each cycle. When count==MUL_CYCLES-1, go to CAPTURE. Exactly MUL_CYCLES RUN cycles.
- CAPTURE (HOLD): on the exiting edge, {hi,lo}<=mulProduct, done<=1, busy<=0, state<=IDLE.

Timing and handshake:
- done is cleared on the following edge, so it is high for exactly one cycle.
- Latency: start sampled at edge E; hi/lo valid and done high after edge E+MUL_CYCLES+2 (E+34 by default).
- busy is high for the cycles between edges E and E+MUL_CYCLES+2.
- start while busy is ignored: no restart, no queueing.
- start with MULTU on the same edge done is asserted is accepted, since state is IDLE at that edge.

Reads:
- MFHI/MFLO reads are purely combinational from hi/lo and are allowed while busy; they return the previous result until CAPTURE.

Other rules:
- Reset mid-multiply aborts. hi/lo return to 0 and the partial product is never captured.
- count never exceeds MUL_CYCLES-1; there is no wrap-around in RUN.
- No arithmetic in this block; mulProduct is split as hi=mulProduct[2*WIDTH-1:WIDTH], lo=mulProduct[WIDTH-1:0].

Optional Feature:
MTHILO_EN.
- Defined: in IDLE, start && funct==MTHI writes hi<=wdata and start && funct==MTLO writes lo<=wdata, both on that edge. No state change, no done pulse. Ignored while busy.
- Undefined: MTHI/MTLO are treated as unknown codes (no effect) and wdata is unused.

Decomposition:
Shared package mul_pkg holds:
- funct localparams MULTU, MFHI, MFLO, MTHI, MTLO;
- multiplier command codes HOLD and OUT;
- the state encoding (2-bit enum IDLE/LOAD/RUN/CAPTURE).

No sub-module. The FSM, counter and HI/LO registers stay in one module; the read mux is a single continuous assignment.

Test Plan:
- Reset asserted mid-RUN at count 10 -> immediately IDLE, mulSignal=HOLD, busy=0, hi=lo=0; no done pulse follows.
- dataA=3, dataB=5, start+MULTU -> mulSignal OUT for 1 cycle then MULTU for 32 cycles; done pulses one cycle after edge E+34; hi=0, lo=15.
- dataA=dataB=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then funct=MFHI gives dataOut=0xFFFFFFFE, MFLO gives 0x00000001, funct=0 gives 0.
- Second start+MULTU at count 5 with different operands -> ignored; result equals the first operands' product; exactly one done pulse.
- Back-to-back: start+MULTU asserted on the done edge -> second multiply begins with no IDLE gap; done pulses again 34 cycles later with the new product.
- With MTHILO_EN: MTHI wdata=0xDEADBEEF in IDLE -> hi=0xDEADBEEF next cycle, lo unchanged, no done. Without MTHILO_EN -> hi unchanged.
